// File: rtl/wddl_pkg.sv
// Shared definitions for the WDDL dual-rail pipeline stage: FSM state type,
// the precharge rail value and the default precharge length.
package wddl_pkg;

  typedef enum logic [1:0] {
    StPre  = 2'd0,
    StIdle = 2'd1,
    StEval = 2'd2
  } wddl_state_e;

  localparam logic [7:0]  WDDL_PRE_VAL     = 8'h00;
  localparam int unsigned WDDL_PRE_CYC_DEF = 1;
  localparam int unsigned WDDL_PRE_CNT_W   = 4;

endpackage

// File: rtl/wddl_rail_chk_8.sv
// Dual-rail validity check: ok is high only when every bit pair is
// complementary (01 or 10), i.e. no precharge (00) or illegal (11) bit.
module wddl_rail_chk_8 (
  input  logic [7:0] p,
  input  logic [7:0] n,
  output logic       ok
);

  assign ok = &(p ^ n);

endmodule

// File: rtl/wddl_pipe_reg8.sv
// WDDL dual-rail pipeline register: precharge / idle / evaluate handshake
// stage with a sticky rail-violation flag and a saturating error counter.
import wddl_pkg::*;

module wddl_pipe_reg8 #(
  parameter int unsigned PRE_CYC = WDDL_PRE_CYC_DEF,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       d_p_in,
  input  logic [7:0]       d_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       q_p_out,
  output logic [7:0]       q_n_out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [WDDL_PRE_CNT_W-1:0] PRE_LOAD = WDDL_PRE_CNT_W'(PRE_CYC);
  localparam logic [ERR_W-1:0]          ERR_MAX  = '1;
  localparam logic [ERR_W-1:0]          ERR_ONE  = ERR_W'(1);

  wddl_state_e               r_state;
  logic [WDDL_PRE_CNT_W-1:0] r_pre_cnt;
  logic [7:0]                r_q_p;
  logic [7:0]                r_q_n;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_err_flag;
  logic [ERR_W-1:0]          r_err_cnt;

  logic w_rail_ok;
  logic w_violation;

  wddl_rail_chk_8 u_rail_chk (
    .p  (d_p_in),
    .n  (d_n_in),
    .ok (w_rail_ok)
  );

  assign w_violation = (r_state == StIdle) && in_valid && !w_rail_ok;

  // Both rails are always written together so q never shows a single-rail value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StPre;
      r_pre_cnt   <= PRE_LOAD;
      r_q_p       <= WDDL_PRE_VAL;
      r_q_n       <= WDDL_PRE_VAL;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StPre: begin
          if (r_pre_cnt < WDDL_PRE_CNT_W'(2)) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b1;
          end else begin
            r_pre_cnt <= r_pre_cnt - WDDL_PRE_CNT_W'(1);
          end
        end
        StIdle: begin
          if (in_valid && w_rail_ok) begin
            r_state     <= StEval;
            r_q_p       <= d_p_in;
            r_q_n       <= d_n_in;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        StEval: begin
          if (out_ready) begin
            r_state     <= StPre;
            r_pre_cnt   <= PRE_LOAD;
            r_q_p       <= WDDL_PRE_VAL;
            r_q_n       <= WDDL_PRE_VAL;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= StPre;
          r_pre_cnt   <= PRE_LOAD;
          r_q_p       <= WDDL_PRE_VAL;
          r_q_n       <= WDDL_PRE_VAL;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // A violation in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end else if (w_violation) begin
      r_err_flag <= 1'b1;
      if (err_clr) begin
        r_err_cnt <= ERR_ONE;
      end else if (r_err_cnt != ERR_MAX) begin
        r_err_cnt <= r_err_cnt + ERR_ONE;
      end
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q_p_out   = r_q_p;
  assign q_n_out   = r_q_n;
  assign err_flag  = r_err_flag;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_wddl_pipe_reg8.sv
// Self-checking bench for wddl_pipe_reg8: directed vector table, hand-written
// reset / saturation / back-to-back sequences and randomized model checking.
module tb_wddl_pipe_reg8;

  localparam int PRE1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_p = 8'h00;
  logic [7:0] d_n = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       in_ready, out_valid, err_flag;
  logic [7:0] q_p, q_n, err_cnt;

  logic       in_valid2 = 1'b0;
  logic       out_ready2 = 1'b0;
  logic       in_ready2, out_valid2, err_flag2;
  logic [7:0] q_p2, q_n2, err_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  wddl_pipe_reg8 #(.PRE_CYC(1), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_p_in    (d_p),
    .d_n_in    (d_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_p_out   (q_p),
    .q_n_out   (q_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt)
  );

  wddl_pipe_reg8 #(.PRE_CYC(2), .ERR_W(8)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_p_in    (d_p),
    .d_n_in    (d_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .q_p_out   (q_p2),
    .q_n_out   (q_n2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .err_clr   (err_clr),
    .err_flag  (err_flag2),
    .err_cnt   (err_cnt2)
  );

  always #5 clk = ~clk;

  // Behavioural model: a held byte, remaining precharge cycles, error state.
  bit         m_held;
  logic [7:0] m_qp, m_qn;
  int         m_pre;
  bit         m_flag;
  int         m_cnt;

  typedef struct {
    logic [7:0] p;
    logic [7:0] n;
    logic       iv;
    logic       ordy;
    logic       clr;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_qp;
    logic [7:0] e_qn;
    logic       e_ef;
    logic [7:0] e_ec;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_qp   = 8'h00;
    m_qn   = 8'h00;
    m_pre  = PRE1;
    m_flag = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    bit rdy;
    bit ok;
    rdy = !m_held && (m_pre == 0);
    ok  = ((d_p ^ d_n) == 8'hFF);
    if (rdy && in_valid && !ok) begin
      m_flag = 1'b1;
      m_cnt  = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (err_clr) begin
      m_flag = 1'b0;
      m_cnt  = 0;
    end
    if (m_held) begin
      if (out_ready) begin
        m_held = 1'b0;
        m_pre  = PRE1;
      end
    end else if (m_pre > 0) begin
      m_pre--;
    end else if (in_valid && ok) begin
      m_held = 1'b1;
      m_qp   = d_p;
      m_qn   = d_n;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (!m_held && m_pre == 0)});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_held});
    chk({tag, ".q_p"},       {24'd0, q_p},       {24'd0, (m_held ? m_qp : 8'h00)});
    chk({tag, ".q_n"},       {24'd0, q_n},       {24'd0, (m_held ? m_qn : 8'h00)});
    chk({tag, ".err_flag"},  {31'd0, err_flag},  {31'd0, m_flag});
    chk({tag, ".err_cnt"},   {24'd0, err_cnt},   32'(m_cnt));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int last_acc;
    int n_acc;
    logic [7:0] prev;

    tbl[0]  = '{8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, 8'd0};
    tbl[1]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, 8'd0};
    tbl[2]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, 8'd0};
    tbl[3]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b0, 8'd0};
    tbl[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
    tbl[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
    tbl[6]  = '{8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'd1};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'd2};
    tbl[8]  = '{8'hF0, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 8'h0F, 1'b0, 8'd0};
    tbl[9]  = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
    tbl[10] = '{8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
    tbl[11] = '{8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hC3, 1'b0, 8'd0};
    tbl[12] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
    tbl[13] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};

    // Reset values while rst_n is held low.
    #3;
    chk("rst.in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.q_p",       {24'd0, q_p},       32'd0);
    chk("rst.q_n",       {24'd0, q_n},       32'd0);
    chk("rst.err_flag",  {31'd0, err_flag},  32'd0);
    chk("rst.err_cnt",   {24'd0, err_cnt},   32'd0);
    chk("rst.in_ready2", {31'd0, in_ready2}, 32'd0);

    apply_reset();
    chk("rel.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rel.q_p",      {24'd0, q_p},      32'd0);
    tick();
    chk("pre_done.in_ready", {31'd0, in_ready}, 32'd1);
    chk("pre_done.q_n",      {24'd0, q_n},      32'd0);

    for (int i = 0; i < 14; i++) begin
      d_p = tbl[i].p;
      d_n = tbl[i].n;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      err_clr   = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d.in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
      chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("vec%0d.q_p", i),       {24'd0, q_p},       {24'd0, tbl[i].e_qp});
      chk($sformatf("vec%0d.q_n", i),       {24'd0, q_n},       {24'd0, tbl[i].e_qn});
      chk($sformatf("vec%0d.err_flag", i),  {31'd0, err_flag},  {31'd0, tbl[i].e_ef});
      chk($sformatf("vec%0d.err_cnt", i),   {24'd0, err_cnt},   {24'd0, tbl[i].e_ec});
    end
    out_ready = 1'b0;
    err_clr   = 1'b0;

    // Saturation: 300 violations, then clear coinciding with a violation.
    d_p = 8'h01;
    d_n = 8'h01;
    in_valid = 1'b1;
    repeat (300) tick();
    chk("sat.err_cnt",  {24'd0, err_cnt},  32'hFF);
    chk("sat.err_flag", {31'd0, err_flag}, 32'd1);
    chk("sat.in_ready", {31'd0, in_ready}, 32'd1);
    err_clr = 1'b1;
    tick();
    chk("clr_viol.err_cnt",  {24'd0, err_cnt},  32'd1);
    chk("clr_viol.err_flag", {31'd0, err_flag}, 32'd1);
    err_clr  = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset while a byte is held.
    d_p = 8'hC3;
    d_n = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("eval.out_valid", {31'd0, out_valid}, 32'd1);
    chk("eval.q_p",       {24'd0, q_p},       32'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.q_p",       {24'd0, q_p},       32'd0);
    chk("async.q_n",       {24'd0, q_n},       32'd0);
    chk("async.out_valid", {31'd0, out_valid}, 32'd0);
    chk("async.err_cnt",   {24'd0, err_cnt},   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_model("post_async");

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      d_p = 8'($urandom);
      d_n = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~d_p;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      tick();
      check_model("rnd");
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;

    // Back-to-back on the PRE_CYC=2 instance.
    apply_reset();
    in_valid2  = 1'b1;
    out_ready2 = 1'b1;
    last_acc = -1;
    n_acc = 0;
    for (int k = 1; k <= 20; k++) begin
      d_p  = 8'(k * 7 + 1);
      d_n  = ~d_p;
      prev = d_p;
      @(posedge clk);
      #1;
      if (out_valid2) begin
        n_acc++;
        chk($sformatf("b2b%0d.q_p", k), {24'd0, q_p2}, {24'd0, prev});
        chk($sformatf("b2b%0d.q_n", k), {24'd0, q_n2}, {24'd0, ~prev});
        if (last_acc < 0) chk("b2b.first", 32'(k), 32'd3);
        else chk($sformatf("b2b%0d.spacing", k), 32'(k - last_acc), 32'd4);
        last_acc = k;
      end else begin
        chk($sformatf("b2b%0d.q_pre", k), {16'd0, q_p2, q_n2}, 32'd0);
      end
    end
    chk("b2b.count",    32'(n_acc),        32'd5);
    chk("b2b.err_flag", {31'd0, err_flag2}, 32'd0);
    chk("b2b.err_cnt",  {24'd0, err_cnt2},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wddl_pipe_reg8.md
WDDL_PIPE_REG8 -- requirements
Module: wddl_pipe_reg8

Interface
REQ-001 Parameter PRE_CYC, default 1, sets the number of mandatory precharge cycles after each evaluation (range 1..15).
REQ-002 Parameter ERR_W, default 8, sets the width of the rail-error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 d_p_in  input  8  true rail of the dual-rail byte from the upstream wddl_xor6_8 output.
REQ-006 d_n_in  input  8  false rail of the same byte.
REQ-007 in_valid  input  1  upstream evaluate-phase data present.
REQ-008 in_ready  output  1  block accepts data this cycle.
REQ-009 q_p_out  output  8  registered true rail to the downstream stage.
REQ-010 q_n_out  output  8  registered false rail.
REQ-011 out_valid  output  1  q rails hold an evaluated byte.
REQ-012 out_ready  input  1  downstream has consumed the byte.
REQ-013 err_clr  input  1  synchronous clear of err_flag and err_cnt.
REQ-014 err_flag  output  1  sticky rail-violation flag.
REQ-015 err_cnt  output  ERR_W  saturating count of rejected inputs.

Function
REQ-016 FSM states: PRE, IDLE, EVAL.
REQ-017 In PRE and IDLE, q_p_out and q_n_out SHALL both be 8'h00 (the WDDL precharge value), and out_valid SHALL be 0.
REQ-018 In PRE, in_ready SHALL be 0, and a down-counter SHALL run PRE_CYC cycles before the FSM moves to IDLE.
REQ-019 In IDLE, in_ready SHALL be 1.
REQ-020 In IDLE, in_valid=1 with every bit complementary (d_p_in ^ d_n_in == 8'hFF) SHALL capture both rails on that edge and move the FSM to EVAL.
REQ-021 In IDLE, in_valid=1 with any bit at 00 or 11 SHALL NOT capture, SHALL set err_flag, SHALL increment err_cnt, and the FSM SHALL stay in IDLE.
REQ-022 In EVAL, out_valid SHALL be 1, in_ready SHALL be 0, and q holds the captured byte; in_valid is ignored.
REQ-023 In EVAL, out_ready=1 SHALL move the FSM to PRE on the same edge, clearing q to 8'h00 and reloading the precharge counter.
REQ-024 Latency from accepted input to out_valid SHALL be 1 cycle; the minimum accept-to-accept spacing SHALL be PRE_CYC+2 cycles.
REQ-025 err_cnt SHALL saturate at all-ones and never wrap.
REQ-026 err_clr and a new violation in the same cycle: the violation SHALL win, giving err_flag=1 and err_cnt=1.
REQ-027 The in_ready and out_valid outputs SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-028 rst_n low SHALL immediately force the FSM to PRE, the precharge counter to PRE_CYC, q rails to 8'h00, out_valid=0, in_ready=0, err_flag=0 and err_cnt=0.
REQ-029 Reset asserted mid-EVAL SHALL discard the held byte; no partial or single-rail value SHALL appear on q.
REQ-030 After rst_n deasserts, the block SHALL complete a full PRE_CYC precharge before in_ready rises.

Structure
REQ-031 Shared package wddl_pkg SHALL hold the FSM state type, the precharge constant WDDL_PRE_VAL (8'h00), and the PRE_CYC default.
REQ-032 Combinational rail validity checking SHALL live in sub-module wddl_rail_chk_8, with inputs p[7:0] and n[7:0] and output ok (1 when all bits are complementary).
REQ-033 The top-level module SHALL contain only the FSM, the counters and the dual-rail registers.

Verification
REQ-034 Reset release with PRE_CYC=1: in_ready SHALL be 0 for 1 cycle, then 1; q SHALL be 00/00 throughout.
REQ-035 Valid byte accept: d_p=8'hA5, d_n=8'h5A, in_valid=1 in IDLE -> next cycle q_p=A5, q_n=5A, out_valid=1; with out_ready held 0 for 3 cycles the byte SHALL stay stable.
REQ-036 Rail violation: d_p=8'h01, d_n=8'h01 in IDLE -> no capture, err_flag=1, err_cnt=1, FSM stays in IDLE.
REQ-037 Error handling: 300 consecutive violations -> err_cnt=8'hFF; then err_clr together with a violation -> err_cnt=1.
REQ-038 Reset mid-transaction: rst_n pulsed low during EVAL -> q=00/00 and out_valid=0 asynchronously, before the next clock edge.
REQ-039 Back-to-back traffic: out_ready tied high with PRE_CYC=2 -> accepts exactly every 4 cycles, and q returns to 00/00 between consecutive bytes.
